raster_prim_fetch: RTL

- Consumes a latched raster_csrs_t job descriptor and walks the primitive-index list at pidx_addr, fetching pidx_size 32-bit indices.
- Converts each index into a primitive-data address (pbuf_addr + idx*pbuf_stride).
- Emits one record per primitive, tagged with the tile rectangle, to the downstream edge-setup/tile-walker stage.
- Sits directly downstream of the raster CSR block; it is the first stage of the raster pipeline.

---
 rtl/raster_types_pkg.sv | 31 +++
 rtl/raster_rsp_buf.sv | 50 +++++
 rtl/raster_prim_fetch.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/raster_types_pkg.sv
// Shared types for the raster pipeline front end: CSR job descriptor,
// per-primitive record and the primitive-fetch FSM encoding.
package raster_types;

  localparam int RASTER_CSR_DATA_BITS = 32;
  localparam int RASTER_TILE_BITS     = 16;
  localparam int RASTER_PIDX_BYTES    = 4;

  typedef struct packed {
    logic [RASTER_CSR_DATA_BITS-1:0] pidx_addr;
    logic [RASTER_CSR_DATA_BITS-1:0] pidx_size;
    logic [RASTER_CSR_DATA_BITS-1:0] pbuf_addr;
    logic [RASTER_CSR_DATA_BITS-1:0] pbuf_stride;
    logic [RASTER_TILE_BITS-1:0]     tile_left;
    logic [RASTER_TILE_BITS-1:0]     tile_top;
    logic [RASTER_TILE_BITS-1:0]     tile_width;
    logic [RASTER_TILE_BITS-1:0]     tile_height;
  } raster_csrs_t;

  typedef struct packed {
    logic [RASTER_CSR_DATA_BITS-1:0] prim_addr;
    logic [RASTER_TILE_BITS-1:0]     tile_left;
    logic [RASTER_TILE_BITS-1:0]     tile_top;
    logic [RASTER_TILE_BITS-1:0]     tile_width;
    logic [RASTER_TILE_BITS-1:0]     tile_height;
    logic                            last;
  } raster_prim_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} raster_fetch_state_t;

endpackage

// File: rtl/raster_rsp_buf.sv
// Synchronous FIFO holding index-read responses until the output slot
// can take them.
module raster_rsp_buf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers and count, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/raster_prim_fetch.sv
// First raster stage: walks the primitive-index list and emits one tile-tagged
// primitive record per index. Define RASTER_PRIM_FETCH_PERF_EN for stall counters.
module raster_prim_fetch
  import raster_types::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_BITS        = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start_valid,
  output logic                            start_ready,
  input  raster_csrs_t                    start_csrs,
  output logic                            mem_req_valid,
  output logic [RASTER_CSR_DATA_BITS-1:0] mem_req_addr,
  input  logic                            mem_req_ready,
  input  logic                            mem_rsp_valid,
  input  logic [31:0]                     mem_rsp_data,
  output logic                            mem_rsp_ready,
  output logic                            prim_valid,
  output raster_prim_t                    prim_data,
  input  logic                            prim_ready,
  output logic                            busy,
  output logic                            done
`ifdef RASTER_PRIM_FETCH_PERF_EN
  ,
  output logic [31:0]                     perf_mem_stall,
  output logic [31:0]                     perf_out_stall
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  raster_fetch_state_t             state;
  raster_csrs_t                    csrs;
  logic [CNT_BITS-1:0]             issued;
  logic [CNT_BITS-1:0]             returned;
  logic [CNT_BITS-1:0]             emitted;
  logic [CNT_BITS-1:0]             size_ext;
  logic [CNT_BITS-1:0]             outstanding;
  logic [CW-1:0]                   buf_count;
  logic                            buf_empty;
  logic                            buf_full;
  logic [31:0]                     buf_head;
  logic [31:0]                     slot_idx;
  logic [RASTER_CSR_DATA_BITS-1:0] prim_offset;
  logic                            req_fire;
  logic                            rsp_accept;
  logic                            slot_free;
  logic                            load_slot;
  logic                            buf_push;
  logic                            buf_pop;
  logic                            last_next;

  assign size_ext = CNT_BITS'(csrs.pidx_size);

  // The output slot counts against credits, so a stalled downstream caps
  // the reads in flight at MAX_OUTSTANDING rather than one more.
  assign outstanding = (issued - returned) + CNT_BITS'(buf_count) + CNT_BITS'(prim_valid);

  assign mem_req_valid = (state == FETCH) && (outstanding < CNT_BITS'(MAX_OUTSTANDING))
                         && (issued < size_ext);
  assign mem_req_addr  = csrs.pidx_addr
                         + RASTER_CSR_DATA_BITS'(issued) * RASTER_CSR_DATA_BITS'(RASTER_PIDX_BYTES);
  assign mem_rsp_ready = 1'b1;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_accept    = mem_rsp_valid && ((state == FETCH) || (state == DRAIN));

  // An empty buffer lets a response go straight to the output slot.
  assign slot_free   = !prim_valid || prim_ready;
  assign load_slot   = slot_free && (!buf_empty || rsp_accept);
  assign buf_pop     = slot_free && !buf_empty;
  assign buf_push    = rsp_accept && !(buf_empty && slot_free) && !buf_full;
  assign slot_idx    = buf_empty ? mem_rsp_data : buf_head;
  assign prim_offset = RASTER_CSR_DATA_BITS'(slot_idx * csrs.pbuf_stride);
  assign last_next   = (emitted + CNT_BITS'(prim_valid)) == (size_ext - CNT_BITS'(1));

  raster_rsp_buf #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (32)
  ) u_rsp_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (buf_push),
    .push_data (mem_rsp_data),
    .pop       (buf_pop),
    .pop_data  (buf_head),
    .empty     (buf_empty),
    .full      (buf_full),
    .count     (buf_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      csrs       <= '0;
      issued     <= '0;
      returned   <= '0;
      emitted    <= '0;
      prim_valid <= 1'b0;
      prim_data  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (req_fire)                issued   <= issued + 1'b1;
      if (rsp_accept)              returned <= returned + 1'b1;
      if (prim_valid && prim_ready) emitted <= emitted + 1'b1;

      if (load_slot) begin
        prim_valid <= 1'b1;
        prim_data  <= '{prim_addr:   csrs.pbuf_addr + prim_offset,
                        tile_left:   csrs.tile_left,
                        tile_top:    csrs.tile_top,
                        tile_width:  csrs.tile_width,
                        tile_height: csrs.tile_height,
                        last:        last_next};
      end else if (prim_ready) begin
        prim_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_valid) begin
            csrs     <= start_csrs;
            issued   <= '0;
            returned <= '0;
            emitted  <= '0;
            if (start_csrs.pidx_size == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: if (req_fire && (issued == size_ext - CNT_BITS'(1))) state <= DRAIN;
        DRAIN: begin
          if (emitted == size_ext) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);

`ifdef RASTER_PRIM_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_mem_stall <= '0;
      perf_out_stall <= '0;
    end else begin
      if (mem_req_valid && !mem_req_ready && (perf_mem_stall != '1))
        perf_mem_stall <= perf_mem_stall + 1'b1;
      if (prim_valid && !prim_ready && (perf_out_stall != '1))
        perf_out_stall <= perf_out_stall + 1'b1;
    end
  end
`endif

endmodule
